membrane_history_buffer: RTL
============================

// Module: membrane_history_buffer
//
// PURPOSE
// Per-neuron membrane-potential history store sitting between the last hidden LIF layer and the Q-value accumulator.
// Captures one membrane vector (all neurons) per timestep during an inference, signals when all timesteps are held,
// and serves the accumulator's shared-timestep random reads.
// This is the write/serve side of the read_timestep / membrane_in interface.
// Contents are frozen while the consumer reads; they are released for the next inference by a one-cycle release pulse.
//
// PARAMETERS
// NUM_NEURONS     16  neurons (buffers) in the bank
// NUM_TIMESTEPS   30  timesteps stored per inference (depth of each buffer)
// MEMBRANE_WIDTH  24  signed membrane word width
// TS_WIDTH        $clog2(NUM_TIMESTEPS)  timestep index width (derived, localparam)
//
// PORTS
// clk            in   1                           single clock; all logic on rising edge
// reset_n        in   1                           asynchronous, active-low reset
// wr_valid       in   1                           producer presents one timestep's membrane vector
// wr_ready       out  1                           buffer accepts a vector this cycle
// wr_membrane    in   NUM_NEURONS x MEMBRANE_WIDTH  signed membrane per neuron, written to slot wr_count
// wr_count       out  TS_WIDTH+1                  timesteps currently stored (0..NUM_TIMESTEPS)
// full           out  1                           all NUM_TIMESTEPS stored; drives consumer readiness
// start_pulse    out  1                           one-cycle pulse the cycle after the final write (consumer 'start')
// read_timestep  in   TS_WIDTH                    shared read index from consumer
// membrane_out   out  NUM_NEURONS x MEMBRANE_WIDTH  combinational read data for read_timestep
// release        in   1                           consumer finished; discard history, begin next inference
// overflow       out  1                           sticky: a write was attempted while full
//
// BEHAVIOUR
// - Reset (reset_n=0, async): wr_count=0, full=0, start_pulse=0, overflow=0, state=FILLING. Storage array is not reset.
// - States:
//   - FILLING: wr_ready=1. wr_valid stores wr_membrane[n] into mem[n][wr_count] and increments wr_count.
//     On the write making wr_count==NUM_TIMESTEPS: go to FULL, full=1 and start_pulse=1 on the next cycle.
//   - FULL: wr_ready=0; storage frozen. wr_valid sets overflow=1 and the data is dropped. full stays 1 until release.
//   - release (either state): wr_count<=0, full<=0, state<=FILLING. release wins over a same-cycle wr_valid; that write is not stored.
//     overflow is cleared only by reset_n.
// - wr_ready is decided from the state at the start of the cycle (no combinational path from release to wr_ready).
// - start_pulse lasts exactly 1 cycle per fill and is not re-issued while FULL.
// - Read path: membrane_out[n] = mem[n][read_timestep] combinationally, zero latency, matching a consumer that
//   multiplies in the same cycle it drives read_timestep.
// - Read gating: if read_timestep >= wr_count (unwritten or out of range, incl. indices >= NUM_TIMESTEPS),
//   membrane_out[n]=0. This keeps reads X-free after reset and release.
// - Reads are legal in any state; the consumer only relies on them while full=1.
// - Data is stored bit-exact, signed, with no scaling or saturation.
// - Reset mid-fill: history is abandoned; wr_count=0, and all reads return 0 until rewritten.
// - Storage maps to NUM_NEURONS register files of NUM_TIMESTEPS x MEMBRANE_WIDTH, each with 1 write port and 1 async read port.
//
// TESTING
// (defaults; vector value v(n,t) = {8'h00, n[7:0], t[7:0]})
// 1. Fill: 30 back-to-back wr_valid with v(n,t).
//    -> wr_count 1..30; full=1 and start_pulse=1 for exactly 1 cycle after the 30th write; wr_ready=0.
// 2. Read: while full, read_timestep=17 -> membrane_out[5]=24'h000511, membrane_out[0]=24'h000011;
//    read_timestep=31 -> all zeros.
// 3. Sign/overflow: write 24'hFFFFFF at t=0 for neuron 3, fill; read t=0 -> 24'hFFFFFF.
//    Then wr_valid while full -> data unchanged, overflow=1 (sticky).
// 4. Release with simultaneous wr_valid -> wr_count=0, full=0, nothing stored, all reads 0;
//    next write lands in slot 0; no start_pulse until 30 more writes.
// 5. Partial/reset: write 12 vectors, read t=11 -> v(n,11), t=12 -> 0;
//    assert reset_n mid-cycle -> wr_count=0, full=0, overflow=0 immediately, reads 0.
// 6. Consumer loopback: connect q_accumulator (start<=start_pulse); after done, pulse release, refill with new data
//    -> second Q-values match the golden model for the second data set.

Source files
------------

// File: rtl/membrane_history_buffer.sv
// membrane_history_buffer: per-neuron membrane-potential history store for one inference.
//
// Captures one membrane vector per timestep. Once all timesteps are held, the contents
// are frozen and start_pulse is issued. The consumer then reads them by shared timestep
// index, and release_req clears the buffer for the next inference.
// The release input is named release_req because "release" is a reserved word.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   wr_valid      producer presents one timestep's membrane vector
//   wr_ready      buffer accepts a vector this cycle (FILLING state)
//   wr_membrane   per-neuron membrane words, written to slot wr_count
//   wr_count      timesteps currently stored (0..NUM_TIMESTEPS)
//   full          all NUM_TIMESTEPS stored
//   start_pulse   one-cycle pulse the cycle after the final write
//   read_timestep shared read index from the consumer
//   membrane_out  combinational read data; zero for unwritten or out-of-range slots
//   release_req   consumer finished; discard history and begin the next inference
//   overflow      sticky; a write was attempted while full
module membrane_history_buffer #(
    parameter int NUM_NEURONS    = 16,
    parameter int NUM_TIMESTEPS  = 30,
    parameter int MEMBRANE_WIDTH = 24,
    localparam int TS_WIDTH      = $clog2(NUM_TIMESTEPS)
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           wr_valid,
    output logic                                           wr_ready,
    input  logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0]     wr_membrane,
    output logic [TS_WIDTH:0]                              wr_count,
    output logic                                           full,
    output logic                                           start_pulse,
    input  logic [TS_WIDTH-1:0]                            read_timestep,
    output logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0]     membrane_out,
    input  logic                                           release_req,
    output logic                                           overflow
);
    typedef enum logic {ST_FILLING, ST_FULL} state_t;

    state_t                    state_q, state_d;
    logic [TS_WIDTH:0]         wr_count_q, wr_count_d;
    logic                      start_pulse_q, start_pulse_d;
    logic                      overflow_q, overflow_d;
    logic                      wr_en;
    logic [MEMBRANE_WIDTH-1:0] mem_q [NUM_NEURONS][NUM_TIMESTEPS];

    always_comb begin
        state_d       = state_q;
        wr_count_d    = wr_count_q;
        start_pulse_d = 1'b0;
        overflow_d    = overflow_q | (state_q == ST_FULL && wr_valid);
        wr_en         = 1'b0;
        // release beats a same-cycle write; that write is dropped
        if (release_req) begin
            state_d    = ST_FILLING;
            wr_count_d = '0;
        end else if (state_q == ST_FILLING && wr_valid) begin
            wr_en      = 1'b1;
            wr_count_d = wr_count_q + 1'b1;
            if (wr_count_q == (TS_WIDTH+1)'(NUM_TIMESTEPS - 1)) begin
                state_d       = ST_FULL;
                start_pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FILLING;
            wr_count_q    <= '0;
            start_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            start_pulse_q <= start_pulse_d;
            overflow_q    <= overflow_d;
        end
    end

    // storage is deliberately not reset; the read gate below hides stale contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                mem_q[n][wr_count_q[TS_WIDTH-1:0]] <= wr_membrane[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            membrane_out[n] = ({1'b0, read_timestep} < wr_count_q) ? mem_q[n][read_timestep] : '0;
        end
    end

    assign wr_ready    = (state_q == ST_FILLING);
    assign full        = (state_q == ST_FULL);
    assign wr_count    = wr_count_q;
    assign start_pulse = start_pulse_q;
    assign overflow    = overflow_q;
endmodule
